// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command engine: FSM encodings, opcodes,
// response bytes and frame-length decode.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_ARG = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SEND    = 3'd3,
    ST_WAIT_TX = 3'd4
  } state_e;

  localparam logic [7:0] OP_ON       = 8'hA1;
  localparam logic [7:0] OP_OFF      = 8'hA2;
  localparam logic [7:0] OP_READ     = 8'hB1;
  localparam logic [7:0] OP_READ_ALL = 8'hB2;
  localparam logic [7:0] OP_RESET    = 8'hC1;

  localparam logic [7:0] RSP_ACK  = 8'h55;
  localparam logic [7:0] RSP_NACK = 8'hEE;
  localparam logic [7:0] RSP_RST  = 8'hAA;

  // Opcodes that carry a channel argument byte.
  function automatic logic opcode_is_2byte(input logic [7:0] op);
    case (op)
      OP_ON, OP_OFF, OP_READ: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_engine_timeout_ctr.sv
// Loadable down-counter; expire flags the enabled cycle in which the count
// has already run out, so a load of N-1 gives an N-cycle window.
module cmd_timeout_ctr #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_r;

  // Reload at window start, then count down while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1'b1);
    end
  end

  assign expire = en && !load && (cnt_r == {W{1'b0}});

endmodule

// File: rtl/uart_cmd_engine.sv
// UART command engine: parses 1/2-byte frames, drives channel state and
// returns one response byte per frame through the TX busy handshake.
module uart_cmd_engine
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int ERR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [NUM_CH-1:0] led_state,
  output logic [2:0]        state,
  output logic              cmd_done,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            state_r, next_state_s;
  logic [7:0]        opcode_r, arg_r, tx_data_r, rsp_nx_s;
  logic [NUM_CH-1:0] led_r, led_nx_s;
  logic [ERR_W-1:0]  err_r;
  logic              wait_first_r, err_event_s, expire_s, tmo_load_s, tmo_en_s, arg_ok_s;
  logic [IDX_W-1:0]  arg_idx_s;

  assign arg_ok_s   = (arg_r < 8'(NUM_CH));
  assign arg_idx_s  = arg_r[IDX_W-1:0];
  assign tmo_load_s = (state_r == ST_IDLE) && rx_valid && opcode_is_2byte(rx_data);
  assign tmo_en_s   = (state_r == ST_GET_ARG) && !rx_valid;

  cmd_timeout_ctr #(.W(CNT_W)) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .load     (tmo_load_s),
    .load_val (CNT_W'(TIMEOUT_CYC - 1)),
    .en       (tmo_en_s),
    .expire   (expire_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) next_state_s = opcode_is_2byte(rx_data) ? ST_GET_ARG : ST_EXEC;
        else          next_state_s = ST_IDLE;
      end
      ST_GET_ARG: begin
        if (rx_valid)      next_state_s = ST_EXEC;
        else if (expire_s) next_state_s = ST_SEND;
        else               next_state_s = ST_GET_ARG;
      end
      ST_EXEC: next_state_s = ST_SEND;
      ST_SEND: begin
        if (!tx_busy) next_state_s = ST_WAIT_TX;
        else          next_state_s = ST_SEND;
      end
      ST_WAIT_TX: begin
        // The entry cycle never exits: tx_busy has only just been raised.
        if (!wait_first_r && !tx_busy) next_state_s = ST_IDLE;
        else                           next_state_s = ST_WAIT_TX;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output / datapath decode; bytes arriving outside IDLE and GET_ARG are overruns.
  always_comb begin
    tx_start    = 1'b0;
    cmd_done    = 1'b0;
    led_nx_s    = led_r;
    rsp_nx_s    = tx_data_r;
    err_event_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        err_event_s = 1'b0;
      end
      ST_GET_ARG: begin
        if (expire_s) begin
          rsp_nx_s    = RSP_NACK;
          err_event_s = 1'b1;
        end else begin
          err_event_s = 1'b0;
        end
      end
      ST_EXEC: begin
        err_event_s = rx_valid;
        case (opcode_r)
          OP_ON, OP_OFF: begin
            if (arg_ok_s) begin
              led_nx_s[arg_idx_s] = (opcode_r == OP_ON);
              rsp_nx_s            = RSP_ACK;
            end else begin
              rsp_nx_s    = RSP_NACK;
              err_event_s = 1'b1;
            end
          end
          OP_READ: begin
            if (arg_ok_s) begin
              rsp_nx_s = {7'd0, led_r[arg_idx_s]};
            end else begin
              rsp_nx_s    = RSP_NACK;
              err_event_s = 1'b1;
            end
          end
          OP_READ_ALL: begin
            rsp_nx_s             = 8'h00;
            rsp_nx_s[NUM_CH-1:0] = led_r;
          end
          OP_RESET: begin
            led_nx_s = {NUM_CH{1'b0}};
            rsp_nx_s = RSP_RST;
          end
          default: begin
            rsp_nx_s    = RSP_NACK;
            err_event_s = 1'b1;
          end
        endcase
      end
      ST_SEND: begin
        tx_start    = !tx_busy;
        err_event_s = rx_valid;
      end
      ST_WAIT_TX: begin
        cmd_done    = !wait_first_r && !tx_busy;
        err_event_s = rx_valid;
      end
      default: begin
        err_event_s = 1'b0;
      end
    endcase
  end

  // Frame bytes, response, channel state and saturating error count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_r     <= 8'h00;
      arg_r        <= 8'h00;
      tx_data_r    <= 8'h00;
      led_r        <= {NUM_CH{1'b0}};
      err_r        <= {ERR_W{1'b0}};
      wait_first_r <= 1'b0;
    end else begin
      if ((state_r == ST_IDLE) && rx_valid)    opcode_r <= rx_data;
      if ((state_r == ST_GET_ARG) && rx_valid) arg_r    <= rx_data;
      tx_data_r    <= rsp_nx_s;
      led_r        <= led_nx_s;
      wait_first_r <= (state_r == ST_SEND) && !tx_busy;
      if (err_event_s && (err_r != {ERR_W{1'b1}})) err_r <= err_r + ERR_W'(1'b1);
    end
  end

  assign tx_data   = tx_data_r;
  assign led_state = led_r;
  assign err_cnt   = err_r;
  assign state     = state_r;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Scoreboard bench for uart_cmd_engine: stimulus pushes expected responses,
// a negedge monitor pops and checks them whenever tx_start fires.
`timescale 1ns/1ps
module tb_uart_cmd_engine;

  localparam int NUM_CH = 4;
  localparam int TC     = 16;
  localparam int ERR_W  = 2;
  localparam int TX_LEN = 3;

  logic              clk = 1'b0;
  logic              rst, rx_valid, tx_busy, tx_start, cmd_done, force_busy;
  logic [7:0]        rx_data, tx_data;
  logic [NUM_CH-1:0] led_state;
  logic [2:0]        state;
  logic [ERR_W-1:0]  err_cnt;

  int   cyc = 0, n_chk = 0, n_pass = 0, busy_left = 0;
  int   last_strobe = 0, last_start_cyc = -100, done_cnt = 0, frames_exp = 0, rel_cyc = 0;
  logic start_q = 1'b0;

  typedef struct {logic [7:0] data; logic [3:0] led; int cyc;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_cmd_engine #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(TC), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .led_state(led_state), .state(state),
    .cmd_done(cmd_done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART TX model: busy for TX_LEN cycles starting the cycle after tx_start.
  always @(negedge clk) start_q = tx_start;
  always @(posedge clk) begin
    if (start_q) busy_left <= TX_LEN;
    else if (busy_left > 0) busy_left <= busy_left - 1;
  end
  assign tx_busy = (busy_left != 0) || force_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compare every transmitted response and cmd_done timing.
  always @(negedge clk) begin
    if (!rst && tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_tx_start: got tx_data 0x%0h expected no transmission (cycle %0d)", tx_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tx_data", 32'(tx_data), 32'(mon_e.data));
        chk("led_at_send", 32'(led_state), 32'(mon_e.led));
        chk("busy_low_at_start", 32'(tx_busy), 32'd0);
        if (mon_e.cyc >= 0) chk("start_latency", 32'(cyc), 32'(mon_e.cyc));
      end
      last_start_cyc = cyc;
    end
    if (!rst && cmd_done === 1'b1) begin
      chk("done_timing", 32'(cyc), 32'(last_start_cyc + TX_LEN + 1));
      done_cnt++;
    end
  end

  task automatic do_reset();
    rx_valid = 1'b0; force_busy = 1'b0; rst = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_led", 32'(led_state), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_cmd_done", 32'(cmd_done), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b; last_strobe = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'hA1;
  endtask

  task automatic wait_done();
    int i = 0;
    while (done_cnt < frames_exp && i < 400) begin
      @(posedge clk); #1; i++;
    end
    chk("frame_done", 32'(done_cnt), 32'(frames_exp));
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] arg, input bit two,
                       input logic [7:0] rsp, input logic [3:0] led);
    send_byte(op);
    if (two) send_byte(arg);
    exp_q.push_back('{rsp, led, last_strobe + 2});
    frames_exp++;
    wait_done();
  endtask

  initial begin
    bit found;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; force_busy = 1'b0;
    do_reset();
    #1 chk_reset_vals();

    // 2-byte ON frame
    frame(8'hA1, 8'h02, 1'b1, 8'h55, 4'b0100);
    chk("t1_led", 32'(led_state), 32'h4);
    chk("t1_err", 32'(err_cnt), 32'd0);

    // ON, READ, READ_ALL, RESET
    do_reset();
    frame(8'hA1, 8'h01, 1'b1, 8'h55, 4'b0010);
    frame(8'hB1, 8'h01, 1'b1, 8'h01, 4'b0010);
    frame(8'hB2, 8'h00, 1'b0, 8'h02, 4'b0010);
    frame(8'hC1, 8'h00, 1'b0, 8'hAA, 4'b0000);
    chk("t2_led", 32'(led_state), 32'h0);

    // Out-of-range channel and invalid opcode
    do_reset();
    frame(8'hA1, 8'h00, 1'b1, 8'h55, 4'b0001);
    frame(8'hA1, 8'h07, 1'b1, 8'hEE, 4'b0001);
    frame(8'h33, 8'h00, 1'b0, 8'hEE, 4'b0001);
    chk("t3_led", 32'(led_state), 32'h1);
    chk("t3_err", 32'(err_cnt), 32'd2);

    // Argument timeout, then next byte parsed as an opcode
    do_reset();
    frame(8'hA1, 8'h03, 1'b1, 8'h55, 4'b1000);
    send_byte(8'hA2);
    exp_q.push_back('{8'hEE, 4'b1000, last_strobe + TC + 1});
    frames_exp++;
    wait_done();
    chk("t4_err", 32'(err_cnt), 32'd1);
    frame(8'hB2, 8'h00, 1'b0, 8'h08, 4'b1000);
    chk("t4_err_after", 32'(err_cnt), 32'd1);

    // TX held busy with overrun bytes during SEND
    do_reset();
    force_busy = 1'b1;
    send_byte(8'hA1);
    send_byte(8'h01);
    exp_q.push_back('{8'h55, 4'b0010, -1});
    frames_exp++;
    send_byte(8'hC1);
    send_byte(8'hB2);
    repeat (44) @(posedge clk);
    #1 chk("t5_state_send", 32'(state), 32'd3);
    @(posedge clk); #1 force_busy = 1'b0; rel_cyc = cyc;
    wait_done();
    chk("t5_start_after_release", 32'(last_start_cyc), 32'(rel_cyc));
    chk("t5_err", 32'(err_cnt), 32'd2);
    chk("t5_led", 32'(led_state), 32'h2);
    frame(8'hB2, 8'h00, 1'b0, 8'h02, 4'b0010);

    // Reset in GET_ARG
    do_reset();
    frame(8'hA1, 8'h00, 1'b1, 8'h55, 4'b0001);
    send_byte(8'hA2);
    repeat (3) @(posedge clk);
    #1 chk("t6_state_get_arg", 32'(state), 32'd1);
    rst = 1'b1;
    #1 chk_reset_vals();
    @(posedge clk); #2 rst = 1'b0;

    // Reset in WAIT_TX
    frame(8'hA1, 8'h03, 1'b1, 8'h55, 4'b1000);
    send_byte(8'hA1);
    send_byte(8'h01);
    exp_q.push_back('{8'h55, 4'b1010, last_strobe + 2});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      if (state == 3'd4) found = 1'b1;
    end
    chk("t6_reach_wait_tx", 32'(state), 32'd4);
    rst = 1'b1;
    #1 chk_reset_vals();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("t6_idle_after_rst", 32'(state), 32'd0);

    // Overrun in the same cycle as a NACK counts once; counter saturates
    do_reset();
    @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h33; last_strobe = cyc;
    @(posedge clk); #1 rx_data = 8'h44;
    @(posedge clk); #1 rx_valid = 1'b0; rx_data = 8'hA1;
    exp_q.push_back('{8'hEE, 4'b0000, last_strobe + 2});
    frames_exp++;
    wait_done();
    chk("dual_error_single_inc", 32'(err_cnt), 32'd1);
    frame(8'h33, 8'h00, 1'b0, 8'hEE, 4'b0000);
    frame(8'h5A, 8'h00, 1'b0, 8'hEE, 4'b0000);
    chk("err_reach_max", 32'(err_cnt), 32'd3);
    frame(8'h00, 8'h00, 1'b0, 8'hEE, 4'b0000);
    chk("err_saturate", 32'(err_cnt), 32'd3);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
- Multi-channel, multi-byte successor to the single-byte UART command decoder.
- Sits between the UART RX synchroniser (rx_valid/rx_data) and the UART TX (tx_start/tx_data/tx_busy).
- Parses 1- or 2-byte command frames and drives a NUM_CH-wide LED/GPIO state vector.
- Returns one response byte per frame with a proper TX busy handshake, an inter-byte timeout and a saturating error counter.

Parameters:
- NUM_CH, 4, number of controllable channels (1..8).
- TIMEOUT_CYC, 1000, clk cycles allowed between opcode byte and argument byte.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_busy  in  1  UART TX busy; rises the cycle after tx_start and stays high until the byte is sent.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  8  response byte; held stable from tx_start until the return to IDLE.
- led_state  out  NUM_CH  channel on/off state.
- state  out  3  current FSM state encoding (debug).
- cmd_done  out  1  one-cycle pulse when a frame's response has completed.
- err_cnt  out  ERR_W  saturating count of NACKs, timeouts and overruns.

Behaviour:
- Reset values: tx_start=0, tx_data=0x00, led_state=0, state=IDLE, cmd_done=0, err_cnt=0, timeout counter=0.
- States: IDLE=0, GET_ARG=1, EXEC=2, SEND=3, WAIT_TX=4.
- Opcodes:
  - 0xA1 ON ch (2-byte)
  - 0xA2 OFF ch (2-byte)
  - 0xB1 READ ch (2-byte)
  - 0xB2 READ_ALL (1-byte)
  - 0xC1 RESET (1-byte)
  - Any other opcode is invalid.
- IDLE:
  - on rx_valid, latch rx_data as opcode.
  - 2-byte opcode -> GET_ARG, clear timeout counter.
  - Otherwise (1-byte or invalid) -> EXEC.
- GET_ARG:
  - on rx_valid, latch the argument byte -> EXEC.
  - Else increment the timeout counter. When it reaches TIMEOUT_CYC-1 without rx_valid -> SEND with tx_data=0xEE; err_cnt+1.
- EXEC (one cycle): compute the response and update led_state, then -> SEND.
  - ON/OFF with arg<NUM_CH: set/clear led_state[arg]; response 0x55.
  - READ with arg<NUM_CH: response {7'd0, led_state[arg]}, using the pre-update value.
  - READ_ALL: response led_state zero-extended to 8 bits.
  - RESET: led_state=0; response 0xAA.
  - Arg>=NUM_CH, or invalid opcode: response 0xEE; led_state unchanged; err_cnt+1.
- SEND:
  - While tx_busy=1, wait with tx_start=0.
  - When tx_busy=0, pulse tx_start for one cycle -> WAIT_TX.
- WAIT_TX:
  - Minimum one cycle.
  - Exits to IDLE on the first cycle after entry with tx_busy=0; cmd_done pulses in that cycle.
- Latency: opcode strobe to tx_start is 2 cycles for a 1-byte frame, and 2 cycles after the argument strobe for a 2-byte frame, when tx_busy=0.
- Overrun: rx_valid in EXEC, SEND or WAIT_TX drops the byte, err_cnt+1; the FSM is unaffected.
- err_cnt saturates at all-ones; it never wraps.
- If two error events occur in one cycle, err_cnt increments by 1 only.
- Reset mid-frame or mid-send: immediate return to reset values; no tx_start is emitted.
- Only rx_valid is sampled; rx_data is ignored when rx_valid=0.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - state encodings;
  - opcode constants (A1, A2, B1, B2, C1);
  - response constants (ACK 0x55, NACK 0xEE, RST 0xAA);
  - the opcode_is_2byte function.
- One natural sub-module, cmd_timeout_ctr: a loadable down-counter with an expiry pulse, reusable by later RX framers.

Test Plan:
1. A1,02 with tx_busy=0 -> led_state=0100, tx_data=0x55, one tx_start pulse 2 cycles after the second strobe, cmd_done after it.
2. A1,01 then B1,01 then B2 -> responses 0x55, 0x01, 0x02; then C1 -> 0xAA and led_state=0000.
3. A1,07 (NUM_CH=4) and opcode 0x33 -> both respond 0xEE, led_state unchanged, err_cnt=2.
4. A2 followed by no byte for TIMEOUT_CYC cycles -> 0xEE sent, err_cnt+1, next byte treated as an opcode.
5. tx_busy held high 50 cycles during SEND, with rx_valid pulses during SEND -> tx_start only after tx_busy falls, each extra byte increments err_cnt, FSM completes normally.
6. rst asserted in GET_ARG and in WAIT_TX -> all outputs return to reset values the same cycle; err_cnt saturation checked with ERR_W=2 (stays at 3).
